debam_accuracy_monitor: RTL and testbench

- On-chip accuracy evaluator for the DeBAM approximate 8x8 multiplier; receiving end of the exact/approximate product stream.
- Consumes (exact, approx) 16-bit product pairs over a valid/ready handshake.
- Per sample, computes the percentage approx*100/exact with a sequential restoring divider, then accumulates it.
- After N_SAMPLES samples, outputs the truncated mean as the effective accuracy percentage.

---
 rtl/debam_pkg.sv | 32 +++
 rtl/seq_divider.sv | 85 ++++++++
 rtl/debam_accuracy_monitor.sv | 218 +++++++++++++++++++++
 tb/tb_debam_accuracy_monitor.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debam_pkg
//  Description : Shared widths, state encoding and constants for the DeBAM
//                accuracy monitor and its sequential divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package debam_pkg;

    localparam int PW       = 16;   // product width (two 8-bit operands)
    localparam int PCT_W    = 23;   // holds (2^PW-1)*100
    localparam int ACC_W    = 32;   // accumulator / final dividend width
    localparam int CNT_W    = 16;   // sample counter width (N_SAMPLES <= 65535)
    localparam int PCT_FULL = 100;  // percentage of an exact match

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ACCEPT     = 3'd1,
        DIV_SAMPLE = 3'd2,
        ACCUM      = 3'd3,
        DIV_FINAL  = 3'd4,
        DONE       = 3'd5
    } state_t;

    // A sample needs no division when it matches exactly or the exact product is zero
    function automatic logic is_special(input logic [PW-1:0] exact_v,
                                        input logic [PW-1:0] approx_v);
        return (approx_v == exact_v) || (exact_v == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Restoring unsigned divider, one quotient bit per cycle.
//                Result (done pulse) arrives NUM_W+1 cycles after start.
//                clr aborts an operation in progress and wins over start.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int NUM_W = 32,
    parameter int DEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quot
);

    localparam int                 c_cnt_w = $clog2(NUM_W + 1);
    localparam logic [c_cnt_w-1:0] c_iters = c_cnt_w'(NUM_W);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [DEN_W-1:0]   r_rem;
    logic [NUM_W-1:0]   r_quot;
    logic [DEN_W-1:0]   r_den;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    logic [DEN_W:0]     w_shift;
    logic               w_ge;
    logic [DEN_W-1:0]   w_sub;

    // Shift the next dividend bit into the partial remainder and trial-subtract;
    // the subtraction only needs DEN_W bits because it is used only when it fits
    assign w_shift = {r_rem, r_quot[NUM_W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_den});
    assign w_sub   = w_shift[DEN_W-1:0] - r_den;

    // Iteration register: load on start, one restoring step per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clr) begin
                r_rem  <= '0;
                r_quot <= '0;
                r_den  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end else if (start) begin
                r_rem  <= '0;
                r_quot <= num;
                r_den  <= den;
                r_cnt  <= c_iters;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem  <= w_ge ? w_sub : w_shift[DEN_W-1:0];
                r_quot <= {r_quot[NUM_W-2:0], w_ge};
                r_cnt  <= r_cnt - c_one;
                if (r_cnt == c_one) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign quot = r_quot;

endmodule
`default_nettype wire

// File: rtl/debam_accuracy_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : debam_accuracy_monitor
//  Description : Accuracy evaluator for the DeBAM approximate multiplier.
//                Accepts (exact, approx) product pairs, computes approx*100/exact
//                per sample, accumulates, and reports floor(sum/N_SAMPLES).
//                Optional macro DEBAM_MISMATCH_CNT_EN adds a 16-bit count of
//                samples whose approximate product differs from the exact one.
//  Revision    : 1.0 - initial release
// ============================================================================
module debam_accuracy_monitor
    import debam_pkg::*;
#(
    parameter int N_SAMPLES = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    exact,
    input  logic [PW-1:0]    approx,
    output logic             busy,
    output logic             done,
`ifdef DEBAM_MISMATCH_CNT_EN
    output logic [15:0]      mismatch_cnt,
`endif
    output logic [PCT_W-1:0] eff_pct
);

    localparam logic [CNT_W-1:0] c_n_samples    = CNT_W'(N_SAMPLES);
    localparam logic [PW-1:0]    c_n_den        = PW'(N_SAMPLES);
    localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);
    localparam logic [ACC_W-1:0] c_pct_full_acc = ACC_W'(PCT_FULL);
    localparam logic [PCT_W-1:0] c_pct_full     = PCT_W'(PCT_FULL);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_in_ready;
    logic               r_done;
    logic [PCT_W-1:0]   r_pct;
    logic [PCT_W-1:0]   r_eff_pct;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_count;

    logic               w_hs;
    logic               w_special;
    logic [ACC_W-1:0]   w_scaled;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_last;
    logic               w_div_start;
    logic [ACC_W-1:0]   w_div_num;
    logic [PW-1:0]      w_div_den;
    logic               w_div_busy;
    logic               w_div_done;
    logic [ACC_W-1:0]   w_div_quot;
    logic               w_unused_div;

    assign w_hs      = in_valid & r_in_ready;
    assign w_special = is_special(exact, approx);
    assign w_scaled  = ACC_W'(approx) * c_pct_full_acc;
    assign w_acc_nxt = r_acc + ACC_W'(r_pct);
    assign w_cnt_nxt = r_count + c_cnt_one;
    assign w_last    = (w_cnt_nxt == c_n_samples);

    // The divider's busy flag and high quotient bits are not needed here
    assign w_unused_div = &{1'b0, w_div_busy, w_div_quot[ACC_W-1:PCT_W]};

    // One divider shared by per-sample and final divisions; start aborts it
    seq_divider #(
        .NUM_W (ACC_W),
        .DEN_W (PW)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .start (w_div_start),
        .num   (w_div_num),
        .den   (w_div_den),
        .busy  (w_div_busy),
        .done  (w_div_done),
        .quot  (w_div_quot)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and divider launch; start overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_div_start = 1'b0;
        w_div_num   = '0;
        w_div_den   = '0;
        if (start) begin
            w_state_nxt = ACCEPT;
        end else begin
            case (r_state)
                ACCEPT: begin
                    if (w_hs) begin
                        if (w_special) begin
                            w_state_nxt = ACCUM;
                        end else begin
                            w_div_start = 1'b1;
                            w_div_num   = w_scaled;
                            w_div_den   = exact;
                            w_state_nxt = DIV_SAMPLE;
                        end
                    end
                end
                DIV_SAMPLE: begin
                    if (w_div_done) begin
                        w_state_nxt = ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_last) begin
                        w_div_start = 1'b1;
                        w_div_num   = w_acc_nxt;
                        w_div_den   = c_n_den;
                        w_state_nxt = DIV_FINAL;
                    end else begin
                        w_state_nxt = ACCEPT;
                    end
                end
                DIV_FINAL: begin
                    if (w_div_done) begin
                        w_state_nxt = DONE;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // Datapath: per-sample percentage, accumulator, counter and final result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
            r_done     <= 1'b0;
            r_pct      <= '0;
            r_eff_pct  <= '0;
            r_acc      <= '0;
            r_count    <= '0;
        end else begin
            r_in_ready <= (w_state_nxt == ACCEPT);
            if (start) begin
                r_done    <= 1'b0;
                r_pct     <= '0;
                r_eff_pct <= '0;
                r_acc     <= '0;
                r_count   <= '0;
            end else begin
                case (r_state)
                    ACCEPT: begin
                        if (w_hs && w_special) begin
                            r_pct <= (approx == exact) ? c_pct_full : '0;
                        end
                    end
                    DIV_SAMPLE: begin
                        if (w_div_done) begin
                            r_pct <= w_div_quot[PCT_W-1:0];
                        end
                    end
                    ACCUM: begin
                        r_acc   <= w_acc_nxt;
                        r_count <= w_cnt_nxt;
                    end
                    DIV_FINAL: begin
                        if (w_div_done) begin
                            r_eff_pct <= w_div_quot[PCT_W-1:0];
                            r_done    <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef DEBAM_MISMATCH_CNT_EN
    logic        r_mismatch;
    logic [15:0] r_mismatch_cnt;

    // Remember whether the accepted sample differed, and count it when accumulated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mismatch     <= 1'b0;
            r_mismatch_cnt <= '0;
        end else if (start) begin
            r_mismatch     <= 1'b0;
            r_mismatch_cnt <= '0;
        end else if ((r_state == ACCEPT) && w_hs) begin
            r_mismatch     <= (approx != exact);
        end else if ((r_state == ACCUM) && r_mismatch) begin
            r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
        end
    end

    assign mismatch_cnt = r_mismatch_cnt;
`endif

    assign in_ready = r_in_ready;
    assign busy     = (r_state != IDLE) && (r_state != DONE);
    assign done     = r_done;
    assign eff_pct  = r_eff_pct;

endmodule
`default_nettype wire

// File: tb/tb_debam_accuracy_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debam_accuracy_monitor
//  Description : Self-checking bench for debam_accuracy_monitor. Three DUTs
//                with N_SAMPLES = 1, 4 and 100; expected results are queued
//                when a run is driven and compared when done rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debam_accuracy_monitor;
    import debam_pkg::*;

    localparam int ND = 3;

    typedef struct {
        logic [PW-1:0] e;
        logic [PW-1:0] a;
        int unsigned   pct;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_s [ND];
    logic             valid_s [ND];
    logic             ready_s [ND];
    logic             busy_s  [ND];
    logic             done_s  [ND];
    logic [PW-1:0]    exact_s [ND];
    logic [PW-1:0]    approx_s[ND];
    logic [PCT_W-1:0] eff_s   [ND];
`ifdef DEBAM_MISMATCH_CNT_EN
    logic [15:0]      mm_s    [ND];
`endif
    int               hs_cnt  [ND];

    int               total = 0;
    int               bad   = 0;
    int unsigned      sb_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        debam_accuracy_monitor #(
            .N_SAMPLES (g == 0 ? 1 : (g == 1 ? 4 : 100))
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .start        (start_s[g]),
            .in_valid     (valid_s[g]),
            .in_ready     (ready_s[g]),
            .exact        (exact_s[g]),
            .approx       (approx_s[g]),
            .busy         (busy_s[g]),
            .done         (done_s[g]),
`ifdef DEBAM_MISMATCH_CNT_EN
            .mismatch_cnt (mm_s[g]),
`endif
            .eff_pct      (eff_s[g])
        );
    end

    // Count accepted samples per DUT since its last start
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (start_s[d])                    hs_cnt[d] <= 0;
            else if (valid_s[d] && ready_s[d]) hs_cnt[d] <= hs_cnt[d] + 1;
        end
    end

    function automatic int unsigned model_pct(input logic [PW-1:0] e, input logic [PW-1:0] a);
        if (a == e)  return 100;
        if (e == '0) return 0;
        return (int'(a) * 100) / int'(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int d);
        start_s[d] = 1'b1;
        tick();
        start_s[d] = 1'b0;
    endtask

    // Present one pair, wait for the handshake, optionally measure cycles to next in_ready
    task automatic send(input int d, input logic [PW-1:0] e, input logic [PW-1:0] a,
                        input bit measure, output int lat);
        int n;
        exact_s[d]  = e;
        approx_s[d] = a;
        valid_s[d]  = 1'b1;
        n = 0;
        while (!ready_s[d] && n < 200) begin
            tick();
            n++;
        end
        if (!ready_s[d]) check("ready_wait", {63'd0, ready_s[d]}, 64'd1);
        tick();
        valid_s[d] = 1'b0;
        lat = 0;
        if (measure) begin
            lat = 1;
            while (!ready_s[d] && lat < 200) begin
                tick();
                lat++;
            end
        end
    endtask

    // Wait for done, then compare eff_pct with the oldest queued expectation
    task automatic wait_done(input int d, input string name);
        int          n;
        int unsigned exp;
        n = 0;
        while (!done_s[d] && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_done"}, {63'd0, done_s[d]}, 64'd1);
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got result with empty expectation queue", name);
        end else begin
            exp = sb_q.pop_front();
            check(name, 64'(eff_s[d]), 64'(exp));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        n1_tab[7];
        vec_t        n4_tab[4];
        int          lat;
        int unsigned sum;
        int          exp_lat;
        int          mm_exp;
        int          seen;
        logic [PW-1:0] e, a;

        n1_tab[0] = '{16'd1234,  16'd1234,  100};
        n1_tab[1] = '{16'd0,     16'd5,     0};
        n1_tab[2] = '{16'd0,     16'd0,     100};
        n1_tab[3] = '{16'd100,   16'd50,    50};
        n1_tab[4] = '{16'd3,     16'd1,     33};
        n1_tab[5] = '{16'd65535, 16'd1,     0};
        n1_tab[6] = '{16'd1,     16'd65535, 6553500};

        n4_tab[0] = '{16'd200, 16'd150, 75};
        n4_tab[1] = '{16'd200, 16'd300, 150};
        n4_tab[2] = '{16'd7,   16'd7,   100};
        n4_tab[3] = '{16'd0,   16'd9,   0};

        for (int d = 0; d < ND; d++) begin
            start_s[d] = 1'b0; valid_s[d] = 1'b0;
            exact_s[d] = '0;   approx_s[d] = '0;
        end
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        for (int d = 0; d < ND; d++) begin
            check("rst_ready", {63'd0, ready_s[d]}, 64'd0);
            check("rst_busy",  {63'd0, busy_s[d]},  64'd0);
            check("rst_done",  {63'd0, done_s[d]},  64'd0);
            check("rst_eff",   64'(eff_s[d]),       64'd0);
        end

        // N_SAMPLES=1 table: special cases and boundary divisions
        for (int i = 0; i < 7; i++) begin
            pulse_start(0);
            check("n1_busy_after_start", {63'd0, busy_s[0]}, 64'd1);
            sb_q.push_back(n1_tab[i].pct);
            send(0, n1_tab[i].e, n1_tab[i].a, 1'b0, lat);
            wait_done(0, "n1_eff");
            check("n1_busy_in_done", {63'd0, busy_s[0]}, 64'd0);
        end
        repeat (3) tick();
        check("n1_done_held", {63'd0, done_s[0]}, 64'd1);
        check("n1_eff_held",  64'(eff_s[0]), 64'd6553500);

        // N_SAMPLES=4: per-sample latency and truncated mean
        pulse_start(1);
        sum = 0;
        for (int i = 0; i < 4; i++) sum += n4_tab[i].pct;
        sb_q.push_back(sum / 4);
        for (int i = 0; i < 4; i++) begin
            send(1, n4_tab[i].e, n4_tab[i].a, i < 3, lat);
            exp_lat = ((n4_tab[i].a == n4_tab[i].e) || (n4_tab[i].e == 0)) ? 2 : 35;
            if (i < 3) check("n4_latency", 64'(lat), 64'(exp_lat));
        end
        wait_done(1, "n4_eff");
        check("n4_accepted", 64'(hs_cnt[1]), 64'd4);

        // Backpressure: valid mostly high (random gaps) while the block is dividing
        pulse_start(1);
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            e = PW'($urandom_range(1, 65535));
            a = PW'($urandom_range(0, 65535));
            sum += model_pct(e, a);
            if (i == 0) sb_q.push_back(0);
            exact_s[1]  = e;
            approx_s[1] = a;
            seen = 0;
            while (!ready_s[1] && seen < 200) begin
                valid_s[1] = ($urandom_range(0, 3) != 0);
                tick();
                seen++;
            end
            valid_s[1] = 1'b1;
            tick();
        end
        void'(sb_q.pop_back());
        sb_q.push_back(sum / 4);
        wait_done(1, "bp_eff");
        check("bp_accepted", 64'(hs_cnt[1]), 64'd4);
        valid_s[1] = 1'b0;

        // Asynchronous reset in the middle of a per-sample division
        pulse_start(0);
        send(0, 16'd200, 16'd150, 1'b0, lat);
        repeat (5) tick();
        check("mid_div_busy", {63'd0, busy_s[0]}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_ready", {63'd0, ready_s[0]}, 64'd0);
        check("arst_busy",  {63'd0, busy_s[0]},  64'd0);
        check("arst_done",  {63'd0, done_s[0]},  64'd0);
        check("arst_eff",   64'(eff_s[0]),       64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        pulse_start(0);
        sb_q.push_back(model_pct(16'd100, 16'd50));
        send(0, 16'd100, 16'd50, 1'b0, lat);
        wait_done(0, "post_rst_eff");

        // start during the final division aborts the run and clears the accumulator
        pulse_start(1);
        send(1, 16'd7, 16'd7, 1'b0, lat);
        send(1, 16'd0, 16'd0, 1'b0, lat);
        send(1, 16'd5, 16'd5, 1'b0, lat);
        send(1, 16'd0, 16'd3, 1'b0, lat);
        repeat (4) tick();
        check("div_final_busy", {63'd0, busy_s[1]}, 64'd1);
        check("div_final_done", {63'd0, done_s[1]}, 64'd0);
        pulse_start(1);
        check("abort_ready", {63'd0, ready_s[1]}, 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_s[1]) seen = 1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        sum = model_pct(16'd200, 16'd100) + model_pct(16'd50, 16'd50)
            + model_pct(16'd0, 16'd0) + model_pct(16'd3, 16'd1);
        sb_q.push_back(sum / 4);
        send(1, 16'd200, 16'd100, 1'b0, lat);
        send(1, 16'd50,  16'd50,  1'b0, lat);
        send(1, 16'd0,   16'd0,   1'b0, lat);
        send(1, 16'd3,   16'd1,   1'b0, lat);
        wait_done(1, "restart_eff");
        check("restart_accepted", 64'(hs_cnt[1]), 64'd4);

        // N_SAMPLES=100 with random multiplier-like pairs
        pulse_start(2);
        sum = 0;
        mm_exp = 0;
        for (int i = 0; i < 100; i++) begin
            e = PW'($urandom_range(0, 255) * $urandom_range(0, 255));
            case ($urandom_range(0, 2))
                0:       a = e;
                1:       a = e ^ PW'(1 << $urandom_range(0, 7));
                default: a = (e > 100) ? e - PW'($urandom_range(1, 100)) : e + 16'd1;
            endcase
            if (a != e) mm_exp++;
            sum += model_pct(e, a);
            send(2, e, a, 1'b0, lat);
        end
        sb_q.push_back(sum / 100);
        wait_done(2, "n100_eff");
        check("n100_accepted", 64'(hs_cnt[2]), 64'd100);
`ifdef DEBAM_MISMATCH_CNT_EN
        check("n100_mismatch", 64'(mm_s[2]), 64'(mm_exp));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
